// File: rtl/alu_pkg.sv
// Shared ALU definitions: result-mux select codes and the divider FSM state type.
// The divider drives the DIV input with its quotient and the MOD input with its remainder.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    AND  = 4'b0010,
    OR   = 4'b0011,
    XOR  = 4'b0100,
    LSR  = 4'b0101,
    LSL  = 4'b0110,
    MOD  = 4'b0111,
    MULT = 4'b1000,
    DIV  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_q_msb,
  input  logic [N-1:0] i_div,
  output logic [N-1:0] o_rem,
  output logic         o_q_bit
);

  logic [N:0] w_t;
  logic       w_ge;

  assign w_t     = {i_rem, i_q_msb};
  assign w_ge    = (w_t >= {1'b0, i_div});
  assign o_q_bit = w_ge;
  // The restored remainder is always below the divisor, so N bits hold it.
  assign o_rem   = w_ge ? N'(w_t - {1'b0, i_div}) : w_t[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/done handshake; a zero divisor
// skips iteration and reports all-ones quotient with the dividend as remainder.
module seq_divider
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int               CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  div_state_t       r_state;
  logic [N-1:0]     r_quo;
  logic [N-1:0]     r_rem;
  logic [N-1:0]     r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_q_out;
  logic [N-1:0]     r_r_out;
  logic             r_dbz;

  logic [N-1:0]     w_rem_next;
  logic             w_q_bit;
  logic [N-1:0]     w_quo_next;

  div_step #(.N(N)) u_step (
    .i_rem   (r_rem),
    .i_q_msb (r_quo[N-1]),
    .i_div   (r_div),
    .o_rem   (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  assign w_quo_next = {r_quo[N-2:0], w_q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RUN: begin
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_q_out <= w_quo_next;
            r_r_out <= w_rem_next;
            r_dbz   <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept a request, allowing back-to-back operations.
          if (start) begin
            r_quo <= a;
            r_rem <= '0;
            r_div <= b;
            r_cnt <= '0;
            if (b == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_q_out <= '1;
              r_r_out <= a;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=4): stimulus pushes expected results with their
// expected completion cycle; a negedge monitor pops and checks on every done pulse.
module tb_seq_divider;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    int q;
    int r;
    int z;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   e0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("div_by_zero", int'(div_by_zero), e.z);
      end
    end
  end

  task automatic push_exp(input int q, input int r, input int z, input int c);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.z   = z;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Pulse start for one cycle; the accepting edge leaves e0 at its cycle index.
  task automatic issue(input int ia, input int ib, input int eq, input int er, input int ez);
    start = 1'b1;
    a     = N'(ia);
    b     = N'(ib);
    @(posedge clk);
    #1;
    start = 1'b0;
    e0    = cyc;
    push_exp(eq, er, ez, (ib == 0) ? e0 : e0 + N);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_quotient"}, int'(quotient), 0);
    check({tag, "_remainder"}, int'(remainder), 0);
    check({tag, "_dbz"}, int'(div_by_zero), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    settle(2);
    check_cleared("reset");
    rst = 1'b0;
    settle(1);

    // 13/3: busy exactly N cycles, then done.
    issue(13, 3, 4, 1, 0);
    for (int k = 0; k < N; k++) begin
      check("busy_run", int'(busy), 1);
      settle(1);
    end
    check("busy_at_done", int'(busy), 0);
    check("done_pulse", int'(done), 1);
    settle(1);
    check("done_clears", int'(done), 0);
    settle(1);

    // Zero divisor fast path.
    issue(7, 0, 15, 7, 1);
    check("dbz_busy", int'(busy), 0);
    check("dbz_done", int'(done), 1);
    settle(1);
    check("dbz_busy_after", int'(busy), 0);
    settle(1);

    // Divisor larger than dividend, then divide by one.
    issue(3, 9, 0, 3, 0);
    settle(N + 1);
    issue(15, 1, 15, 0, 0);
    settle(N + 1);

    // Start held high; operands change mid-run; second op accepted in DONE.
    start = 1'b1;
    a     = 4'd15;
    b     = 4'd4;
    @(posedge clk);
    #1;
    e0 = cyc;
    push_exp(3, 3, 0, e0 + N);
    push_exp(4, 1, 0, e0 + 2 * N + 1);
    settle(2);
    a = 4'd9;
    b = 4'd2;
    settle(3);
    start = 1'b0;
    settle(2);
    check("hold_busy", int'(busy), 1);
    check("hold_quotient", int'(quotient), 3);
    check("hold_remainder", int'(remainder), 3);
    settle(5);

    // Reset during RUN abandons the operation without a done.
    start = 1'b1;
    a     = 4'd13;
    b     = 4'd3;
    settle(1);
    start = 1'b0;
    settle(1);
    rst = 1'b1;
    settle(1);
    rst = 1'b0;
    check_cleared("mid_reset");
    settle(N + 2);
    issue(13, 3, 4, 1, 0);
    settle(N + 1);

    // Exhaustive sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        if (ib == 0) issue(ia, ib, 15, ia, 1);
        else         issue(ia, ib, ia / ib, ia % ib, 0);
        settle(N + 1);
      end
    end

    settle(2);
    check("results_pending", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
